// File: rtl/shift_register.sv
// Serial-in, parallel-out bidirectional shift register with shift enable.
// serial_out exposes the bit that the next enabled shift will discard, for chaining stages.
module shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             direction,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out
);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("shift_register: WIDTH must be in 2..64");
        end
    endgenerate

    logic [WIDTH-1:0] shreg_p0;

    // Stage p0: the register itself; direction is sampled at the same edge as data_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_p0 <= '0;
        end else if (shift_en) begin
            if (direction) begin
                shreg_p0 <= {data_in, shreg_p0[WIDTH-1:1]};
            end else begin
                shreg_p0 <= {shreg_p0[WIDTH-2:0], data_in};
            end
        end
    end

    assign data_out   = shreg_p0;
    assign serial_out = direction ? shreg_p0[0] : shreg_p0[WIDTH-1];

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: an 8-bit and a 4-bit instance share all inputs.
module tb_shift_register;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       shift_en = 1'b0;
    logic       direction = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out8;
    logic       serial_out8;
    logic [3:0] data_out4;
    logic       serial_out4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .shift_en(shift_en), .direction(direction),
        .data_in(data_in), .data_out(data_out8), .serial_out(serial_out8)
    );

    shift_register #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .shift_en(shift_en), .direction(direction),
        .data_in(data_in), .data_out(data_out4), .serial_out(serial_out4)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        shift_en  = 1'b1;
        direction = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_in = ~data_in;
            step();
            n_cmp++;
            if (data_out8 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b expected 00000000", i, data_out8);
            end
        end
        shift_en = 1'b0;
        reset    = 1'b0;
        step();
        n_cmp++;
        if (data_out8 !== 8'h00 || data_out4 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %b/%b expected 00000000/0000", data_out8, data_out4);
        end
    endtask

    task automatic test_left_shift();
        logic [7:0] seq;
        seq = 8'b10101010;
        direction = 1'b0;
        shift_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = seq[7-i];
            step();
            if (i == 0) begin
                n_cmp++;
                if (data_out8 !== 8'b00000001) begin
                    n_fail++;
                    $display("FAIL left_first_edge: got %b expected 00000001", data_out8);
                end
            end
        end
        n_cmp++;
        if (data_out8 !== 8'b10101010 || serial_out8 !== 1'b1) begin
            n_fail++;
            $display("FAIL left_full: got %b so=%b expected 10101010 so=1", data_out8, serial_out8);
        end
        shift_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in = ~data_in;
            step();
            n_cmp++;
            if (data_out8 !== 8'b10101010) begin
                n_fail++;
                $display("FAIL left_hold cycle %0d: got %b expected 10101010", i, data_out8);
            end
        end
    endtask

    task automatic test_right_shift();
        logic [7:0] seq;
        seq = 8'b10101010;
        pulse_reset();
        direction = 1'b1;
        shift_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = seq[7-i];
            step();
            if (i == 0) begin
                n_cmp++;
                if (data_out8 !== 8'b10000000) begin
                    n_fail++;
                    $display("FAIL right_first_edge: got %b expected 10000000", data_out8);
                end
            end
        end
        n_cmp++;
        if (data_out8 !== 8'b01010101 || serial_out8 !== 1'b1) begin
            n_fail++;
            $display("FAIL right_full: got %b so=%b expected 01010101 so=1", data_out8, serial_out8);
        end
        shift_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            direction = i[0];
            step();
            n_cmp++;
            if (data_out8 !== 8'b01010101) begin
                n_fail++;
                $display("FAIL right_hold cycle %0d: got %b expected 01010101", i, data_out8);
            end
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        direction = 1'b0;
        shift_en  = 1'b1;
        data_in   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (data_out8 !== 8'b00000111) begin
            n_fail++;
            $display("FAIL async_pre: got %b expected 00000111", data_out8);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (data_out8 !== 8'h00 || data_out4 !== 4'h0) begin
            n_fail++;
            $display("FAIL async_clear: got %b/%b expected 00000000/0000", data_out8, data_out4);
        end
        shift_en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_direction_change();
        pulse_reset();
        direction = 1'b0;
        shift_en  = 1'b1;
        data_in   = 1'b1;
        step();
        step();
        n_cmp++;
        if (data_out8 !== 8'b00000011 || serial_out8 !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_left2: got %b so=%b expected 00000011 so=0", data_out8, serial_out8);
        end
        direction = 1'b1;
        #1;
        n_cmp++;
        if (serial_out8 !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_so_comb_right: got %b expected 1", serial_out8);
        end
        data_in = 1'b0;
        step();
        n_cmp++;
        if (data_out8 !== 8'b00000001 || serial_out8 !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_right0: got %b so=%b expected 00000001 so=1", data_out8, serial_out8);
        end
        direction = 1'b0;
        #1;
        n_cmp++;
        if (serial_out8 !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_so_comb_left: got %b expected 0", serial_out8);
        end
        data_in = 1'b1;
        step();
        n_cmp++;
        if (data_out8 !== 8'b00000011) begin
            n_fail++;
            $display("FAIL dir_left1: got %b expected 00000011", data_out8);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] seq;
        seq = 5'b10011;
        pulse_reset();
        direction = 1'b0;
        shift_en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = seq[4-i];
            step();
        end
        n_cmp++;
        if (data_out4 !== 4'b0011 || serial_out4 !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_w4: got %b so=%b expected 0011 so=0", data_out4, serial_out4);
        end
        n_cmp++;
        if (data_out8 !== 8'b00010011) begin
            n_fail++;
            $display("FAIL overflow_w8: got %b expected 00010011", data_out8);
        end
        direction = 1'b1;
        #1;
        n_cmp++;
        if (serial_out4 !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_so_right: got %b expected 1", serial_out4);
        end
        shift_en = 1'b0;
    endtask

    initial begin
        #1;
        n_cmp++;
        if (data_out8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_initial: got %b expected 00000000", data_out8);
        end
        test_reset();
        test_left_shift();
        test_right_shift();
        test_async_reset();
        test_direction_change();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
- Parameterised serial-in, parallel-out bidirectional shift register with a shift enable.
- Used as a generic serial-to-parallel converter and bit-stream capture element in datapath and test logic.
- Each enabled clock inserts one serial bit at the LSB (left shift) or at the MSB (right shift).
- Also provides the bit that would be shifted out next, for chaining stages.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64; elaboration-time error outside this range.

Ports:
- clk  input  1  system clock; all state changes on rising edge except reset.
- reset  input  1  asynchronous, active-high reset; clears the register.
- shift_en  input  1  shift enable; 1 = shift on this rising edge, 0 = hold.
- direction  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
- data_in  input  1  serial bit inserted on each enabled shift.
- data_out  output  WIDTH  parallel register contents (registered).
- serial_out  output  1  bit that leaves the register on the next enabled shift (combinational from register and direction).

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-high; the port is named reset.
- Reset:
  - Asserting reset immediately (no clock needed) forces data_out = all zeros.
  - While reset = 1, the register stays zero regardless of shift_en, direction or data_in.
  - After reset deasserts, the first rising edge with shift_en = 1 performs a normal shift.
- Hold: on a rising edge with shift_en = 0, data_out is unchanged. direction and data_in are ignored.
- Left shift (shift_en = 1, direction = 0): next data_out = {data_out[WIDTH-2:0], data_in}.
  - data_in enters bit 0.
  - Old bit WIDTH-1 is discarded.
- Right shift (shift_en = 1, direction = 1): next data_out = {data_in, data_out[WIDTH-1:1]}.
  - data_in enters bit WIDTH-1.
  - Old bit 0 is discarded.
- Latency:
  - A bit sampled at edge N appears in data_out immediately after edge N.
  - After WIDTH consecutive enabled shifts, the first bit sampled is in the MSB (left mode) or the LSB (right mode).
- serial_out:
  - Equals data_out[WIDTH-1] when direction = 0.
  - Equals data_out[0] when direction = 1.
  - Updates combinationally when direction changes.
- Direction may change between any two edges. Each edge uses the direction value sampled at that edge; existing contents are not reordered.
- All inputs are sampled at the rising edge and must be stable around it. No X-propagation special handling is required.
- Reset mid-operation: a partially shifted pattern is lost; the register restarts from zero.
- No overflow or saturation: shifting continues indefinitely and old bits fall off the far end.

Test Plan:
- Reset check: reset = 1 for 2 cycles, with shift_en = 1 and data_in = 1 toggling -> data_out = 00000000 throughout. Deassert reset -> still 00000000 until the first enabled edge.
- Left shift: direction = 0, shift_en = 1, data_in sequence 1,0,1,0,1,0,1,0 on 8 edges, then shift_en = 0 for 2 cycles -> data_out = 10101010 and held. serial_out = 1.
- Right shift: after reset, direction = 1, same sequence 1,0,1,0,1,0,1,0 -> data_out = 01010101 and held during shift_en = 0. serial_out = 1.
- Async reset mid-shift: left-shift 1,1,1 (data_out = 00000111), assert reset between clock edges -> data_out = 00000000 before the next rising edge.
- Direction change: left-shift 1,1 (00000011), then right-shift 0 -> 00000001, then left-shift 1 -> 00000011. serial_out toggles between data_out[7] and data_out[0] as direction changes.
- Overflow/parameter: WIDTH = 4, left-shift 1,0,0,1,1 -> data_out = 0011; the first 1 is discarded.
